vga_scanout_engine: RTL and testbench

//  Parametrised VGA scan-out: pixel-enable divider, H/V timing, linear framebuffer read addressing,

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_timing_core.sv | 86 ++++++++
 rtl/vga_scanout_engine.sv | 202 ++++++++++++++++++++
 tb/tb_vga_scanout_engine.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared timing defaults, pipeline control record and helper
//                functions for the VGA scan-out engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int c_DEF_CLK_DIV  = 4;
    localparam int c_DEF_H_ACTIVE = 640;
    localparam int c_DEF_H_FP     = 16;
    localparam int c_DEF_H_SYNC   = 96;
    localparam int c_DEF_H_BP     = 48;
    localparam int c_DEF_V_ACTIVE = 480;
    localparam int c_DEF_V_FP     = 10;
    localparam int c_DEF_V_SYNC   = 2;
    localparam int c_DEF_V_BP     = 33;
    localparam int c_DEF_PIX_W    = 1;
    localparam int c_DEF_COLOR_W  = 12;

    // Per-pixel control that travels alongside the framebuffer read.
    typedef struct packed {
        logic active;
        logic hsync_n;
        logic vsync_n;
        logic cursor;
    } scan_ctrl_t;

    localparam scan_ctrl_t c_CTRL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, cursor: 1'b0};

    function automatic int calc_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int calc_addr_w(input int h_active, input int v_active);
        return (h_active * v_active > 1) ? $clog2(h_active * v_active) : 1;
    endfunction

    // Entry 0 resets to black, every other entry to all-ones.
    function automatic logic pal_reset_bit(input int idx);
        return (idx != 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_timing_core.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_core
//  Description : Pixel-enable divider and H/V counters producing raw
//                active/sync flags and the frame_end pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_core
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = c_DEF_CLK_DIV,
    parameter int H_ACTIVE = c_DEF_H_ACTIVE,
    parameter int H_FP     = c_DEF_H_FP,
    parameter int H_SYNC   = c_DEF_H_SYNC,
    parameter int H_BP     = c_DEF_H_BP,
    parameter int V_ACTIVE = c_DEF_V_ACTIVE,
    parameter int V_FP     = c_DEF_V_FP,
    parameter int V_SYNC   = c_DEF_V_SYNC,
    parameter int V_BP     = c_DEF_V_BP,
    parameter int H_W      = $clog2(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1),
    parameter int V_W      = $clog2(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1)
) (
    input  logic           clk,
    input  logic           rst,
    output logic           o_pe,
    output logic           o_frame_end,
    output logic [H_W-1:0] o_hcnt,
    output logic [V_W-1:0] o_vcnt,
    output logic           o_active,
    output logic           o_hsync_n,
    output logic           o_vsync_n
);

    localparam int c_H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int c_V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int c_DIV_W   = $clog2(CLK_DIV);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [H_W-1:0]     c_H_LAST   = H_W'(c_H_TOTAL - 1);
    localparam logic [H_W-1:0]     c_H_ACT    = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0]     c_HS_BEG   = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0]     c_HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [V_W-1:0]     c_V_LAST   = V_W'(c_V_TOTAL - 1);
    localparam logic [V_W-1:0]     c_V_ACT    = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0]     c_VS_BEG   = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0]     c_VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [c_DIV_W-1:0] r_div;
    logic [H_W-1:0]     r_hcnt;
    logic [V_W-1:0]     r_vcnt;
    logic               w_pe;
    logic               w_h_last;
    logic               w_v_last;

    assign w_pe     = (r_div == c_DIV_LAST);
    assign w_h_last = (r_hcnt == c_H_LAST);
    assign w_v_last = (r_vcnt == c_V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_pe) begin
            r_div <= '0;
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + V_W'(1);
            end else begin
                r_hcnt <= r_hcnt + H_W'(1);
            end
        end else begin
            r_div <= r_div + c_DIV_W'(1);
        end
    end

    assign o_pe        = w_pe;
    assign o_frame_end = w_pe && w_h_last && w_v_last;
    assign o_hcnt      = r_hcnt;
    assign o_vcnt      = r_vcnt;
    assign o_active    = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign o_hsync_n   = !((r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END));
    assign o_vsync_n   = !((r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END));

endmodule
`default_nettype wire

// File: rtl/vga_scanout_engine.sv
`default_nettype none
// ============================================================================
//  Module      : vga_scanout_engine
//  Description : VGA scan-out with framebuffer read addressing, 2-pixel
//                alignment pipeline and writable palette. Defining
//                CURSOR_OVERLAY_EN adds a button-driven cursor box overlay.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout_engine
    import vga_pkg::*;
#(
    parameter int                 CLK_DIV      = c_DEF_CLK_DIV,
    parameter int                 H_ACTIVE     = c_DEF_H_ACTIVE,
    parameter int                 H_FP         = c_DEF_H_FP,
    parameter int                 H_SYNC       = c_DEF_H_SYNC,
    parameter int                 H_BP         = c_DEF_H_BP,
    parameter int                 V_ACTIVE     = c_DEF_V_ACTIVE,
    parameter int                 V_FP         = c_DEF_V_FP,
    parameter int                 V_SYNC       = c_DEF_V_SYNC,
    parameter int                 V_BP         = c_DEF_V_BP,
    parameter int                 PIX_W        = c_DEF_PIX_W,
    parameter int                 COLOR_W      = c_DEF_COLOR_W,
    parameter int                 RD_LATENCY   = 1,
    parameter int                 CURSOR_SIZE  = 8,
    parameter logic [COLOR_W-1:0] CURSOR_COLOR = COLOR_W'(12'hF00),
    parameter int                 ADDR_W       = calc_addr_w(H_ACTIVE, V_ACTIVE)
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic [ADDR_W-1:0]    pix_rd_addr,
    output logic                 pix_rd_en,
    input  logic [PIX_W-1:0]     pix_rd_data,
    input  logic                 pal_we,
    input  logic [PIX_W-1:0]     pal_idx,
    input  logic [COLOR_W-1:0]   pal_data,
    output logic                 hSync,
    output logic                 vSync,
    output logic [COLOR_W/3-1:0] VGA_R,
    output logic [COLOR_W/3-1:0] VGA_G,
    output logic [COLOR_W/3-1:0] VGA_B,
    output logic                 frame_end
`ifdef CURSOR_OVERLAY_EN
    ,
    input  logic                 BTNU,
    input  logic                 BTND,
    input  logic                 BTNL,
    input  logic                 BTNR
`endif
);

    localparam int c_H_W   = $clog2(calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP) + 1);
    localparam int c_V_W   = $clog2(calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP) + 1);
    localparam int c_PAL_N = 2 ** PIX_W;
    localparam int c_CH_W  = COLOR_W / 3;

    logic             w_pe;
    logic             w_frame_end;
    logic [c_H_W-1:0] w_hcnt;
    logic [c_V_W-1:0] w_vcnt;
    logic             w_raw_active;
    logic             w_raw_hsync_n;
    logic             w_raw_vsync_n;
    logic             w_in_box;
    scan_ctrl_t       w_ctrl_raw;

    vga_timing_core #(
        .CLK_DIV  (CLK_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .H_W      (c_H_W),
        .V_W      (c_V_W)
    ) u_timing (
        .clk         (clk),
        .rst         (reset),
        .o_pe        (w_pe),
        .o_frame_end (w_frame_end),
        .o_hcnt      (w_hcnt),
        .o_vcnt      (w_vcnt),
        .o_active    (w_raw_active),
        .o_hsync_n   (w_raw_hsync_n),
        .o_vsync_n   (w_raw_vsync_n)
    );

    // The read port must answer before the next pixel enable samples it.
    logic w_unused_cfg;
    assign w_unused_cfg = (RD_LATENCY >= CLK_DIV);

`ifdef CURSOR_OVERLAY_EN
    localparam logic [c_H_W-1:0] c_CUR_X_MAX = c_H_W'(H_ACTIVE - CURSOR_SIZE);
    localparam logic [c_V_W-1:0] c_CUR_Y_MAX = c_V_W'(V_ACTIVE - CURSOR_SIZE);
    localparam logic [c_H_W-1:0] c_CUR_W     = c_H_W'(CURSOR_SIZE);
    localparam logic [c_V_W-1:0] c_CUR_H     = c_V_W'(CURSOR_SIZE);

    logic [c_H_W-1:0] r_cur_x;
    logic [c_V_W-1:0] r_cur_y;

    // Opposing buttons on one axis cancel; the box saturates at the edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cur_x <= c_H_W'(H_ACTIVE / 2);
            r_cur_y <= c_V_W'(V_ACTIVE / 2);
        end else if (w_frame_end) begin
            if (BTNL && !BTNR && (r_cur_x != '0)) begin
                r_cur_x <= r_cur_x - c_H_W'(1);
            end else if (BTNR && !BTNL && (r_cur_x < c_CUR_X_MAX)) begin
                r_cur_x <= r_cur_x + c_H_W'(1);
            end
            if (BTNU && !BTND && (r_cur_y != '0)) begin
                r_cur_y <= r_cur_y - c_V_W'(1);
            end else if (BTND && !BTNU && (r_cur_y < c_CUR_Y_MAX)) begin
                r_cur_y <= r_cur_y + c_V_W'(1);
            end
        end
    end

    assign w_in_box = w_raw_active
                   && (w_hcnt >= r_cur_x) && (w_hcnt < r_cur_x + c_CUR_W)
                   && (w_vcnt >= r_cur_y) && (w_vcnt < r_cur_y + c_CUR_H);
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^{w_hcnt, w_vcnt} ^ (CURSOR_SIZE != 0);
    assign w_in_box        = 1'b0;
`endif

    always_comb begin
        w_ctrl_raw         = c_CTRL_IDLE;
        w_ctrl_raw.active  = w_raw_active;
        w_ctrl_raw.hsync_n = w_raw_hsync_n;
        w_ctrl_raw.vsync_n = w_raw_vsync_n;
        w_ctrl_raw.cursor  = w_in_box;
    end

    logic [COLOR_W-1:0] r_pal [c_PAL_N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_PAL_N; i++) begin
                r_pal[i] <= {COLOR_W{pal_reset_bit(i)}};
            end
        end else if (pal_we) begin
            r_pal[pal_idx] <= pal_data;
        end
    end

    logic [ADDR_W-1:0]  r_ptr;
    scan_ctrl_t         r_ctrl_a;
    scan_ctrl_t         r_ctrl_b;
    logic [PIX_W-1:0]   r_idx;
    logic [COLOR_W-1:0] r_rgb;

    // Stage A issues the address, stage B captures the index, the output
    // stage looks up the colour, so syncs and colour stay pixel-aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= '0;
            pix_rd_addr <= '0;
            pix_rd_en   <= 1'b0;
            r_ctrl_a    <= c_CTRL_IDLE;
            r_ctrl_b    <= c_CTRL_IDLE;
            r_idx       <= '0;
            hSync       <= 1'b1;
            vSync       <= 1'b1;
            r_rgb       <= '0;
        end else begin
            pix_rd_en <= w_pe && w_raw_active;
            if (w_pe) begin
                if (w_raw_active) begin
                    pix_rd_addr <= r_ptr;
                    r_ptr       <= r_ptr + ADDR_W'(1);
                end
                if (w_frame_end) begin
                    r_ptr <= '0;
                end
                r_ctrl_a <= w_ctrl_raw;
                r_ctrl_b <= r_ctrl_a;
                r_idx    <= pix_rd_data;
                hSync    <= r_ctrl_b.hsync_n;
                vSync    <= r_ctrl_b.vsync_n;
                if (!r_ctrl_b.active) begin
                    r_rgb <= '0;
                end else if (r_ctrl_b.cursor) begin
                    r_rgb <= CURSOR_COLOR;
                end else begin
                    r_rgb <= r_pal[r_idx];
                end
            end
        end
    end

    assign VGA_R     = r_rgb[3*c_CH_W-1 -: c_CH_W];
    assign VGA_G     = r_rgb[2*c_CH_W-1 -: c_CH_W];
    assign VGA_B     = r_rgb[c_CH_W-1 -: c_CH_W];
    assign frame_end = w_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vga_scanout_engine
//  Description : Directed/random bench with a pixel-index reference model for
//                a reduced 8x4 raster. Cursor steps need CURSOR_OVERLAY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout_engine;

    localparam int DIV = 2;
    localparam int HA = 8, HF = 1, HS = 2, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;
    localparam int PW = 2;
    localparam int CW = 12;
    localparam int AW = 5;
    localparam int CS = 2;
    localparam logic [CW-1:0] CCOL = 12'hF00;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pix_rd_addr;
    logic          pix_rd_en;
    logic [PW-1:0] pix_rd_data = '0;
    logic          pal_we = 1'b0;
    logic [PW-1:0] pal_idx = '0;
    logic [CW-1:0] pal_data = '0;
    logic          hSync, vSync, frame_end;
    logic [3:0]    VGA_R, VGA_G, VGA_B;
`ifdef CURSOR_OVERLAY_EN
    logic BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0;
`endif

    always #5 clk = ~clk;

    vga_scanout_engine #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .PIX_W(PW), .COLOR_W(CW), .RD_LATENCY(1), .CURSOR_SIZE(CS), .CURSOR_COLOR(CCOL)
    ) dut (
        .clk(clk), .reset(reset),
        .pix_rd_addr(pix_rd_addr), .pix_rd_en(pix_rd_en), .pix_rd_data(pix_rd_data),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .hSync(hSync), .vSync(vSync),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .frame_end(frame_end)
`ifdef CURSOR_OVERLAY_EN
        , .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR)
`endif
    );

    // Framebuffer with one clock of read latency.
    logic [PW-1:0] mem [HA*VA];
    always @(posedge clk) pix_rd_data <= mem[pix_rd_addr];

    int n_checks = 0;
    int n_fail   = 0;

    int          c;
    logic [CW-1:0] pal_m [4];
    int          exp_addr;
    bit          exp_en, exp_hs, exp_vs, prev_fe;
    logic [CW-1:0] exp_rgb;
    int          cx, cy;
    bit          cb_hist [8];
    int          green_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, c);
        end
    endtask

    function automatic bit is_act(input int h, input int v);
        return (h < HA) && (v < VA);
    endfunction

    task automatic model_reset();
        c = 0; exp_addr = 0; exp_en = 0; exp_hs = 1; exp_vs = 1; exp_rgb = '0; prev_fe = 0;
        pal_m[0] = '0;
        for (int i = 1; i < 4; i++) pal_m[i] = '1;
        cx = HA / 2; cy = VA / 2;
        for (int i = 0; i < 8; i++) cb_hist[i] = 0;
    endtask

    // One clock: advance the reference timeline, then compare every output.
    task automatic cycle();
        int k, q, p, h, v;
        bit fe_exp;
        @(posedge clk); #1;
        c++;
        if (c % DIV == 0) begin
            k = c / DIV;
            q = k - 1;
            h = q % HT; v = (q / HT) % VT;
            exp_en = is_act(h, v);
            if (exp_en) exp_addr = v * HA + h;
`ifdef CURSOR_OVERLAY_EN
            cb_hist[q % 8] = is_act(h, v) && h >= cx && h < cx + CS && v >= cy && v < cy + CS;
            if (h == HT - 1 && v == VT - 1) begin
                if (BTNL && !BTNR && cx > 0) cx--;
                else if (BTNR && !BTNL && cx < HA - CS) cx++;
                if (BTNU && !BTND && cy > 0) cy--;
                else if (BTND && !BTNU && cy < VA - CS) cy++;
            end
`else
            cb_hist[q % 8] = 0;
`endif
            p = k - 3;
            if (p < 0) begin
                exp_hs = 1; exp_vs = 1; exp_rgb = '0;
            end else begin
                h = p % HT; v = (p / HT) % VT;
                exp_hs = !(h >= HA + HF && h < HA + HF + HS);
                exp_vs = !(v >= VA + VF && v < VA + VF + VS);
                if (!is_act(h, v))      exp_rgb = '0;
                else if (cb_hist[p % 8]) exp_rgb = CCOL;
                else                     exp_rgb = pal_m[mem[v * HA + h]];
            end
        end else begin
            exp_en = 0;
        end
        if (pal_we) pal_m[pal_idx] = pal_data;
        fe_exp = ((c + 1) % DIV == 0) && ((((c + 1) / DIV) - 1) % FR == FR - 1);
        chk("pix_rd_en", 32'(pix_rd_en), 32'(exp_en));
        chk("pix_rd_addr", 32'(pix_rd_addr), 32'(exp_addr));
        chk("hSync", 32'(hSync), 32'(exp_hs));
        chk("vSync", 32'(vSync), 32'(exp_vs));
        chk("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
        chk("frame_end", 32'(frame_end), 32'(fe_exp));
        chk("frame_end_consecutive", 32'(frame_end & prev_fe), 32'd0);
        prev_fe = frame_end;
        if ({VGA_R, VGA_G, VGA_B} == 12'h0F0) green_cnt++;
    endtask

    task automatic run(input int n, input bit rand_pal);
        for (int i = 0; i < n; i++) begin
            if (rand_pal && $urandom_range(0, 15) == 0) begin
                pal_we = 1'b1;
                pal_idx = PW'($urandom_range(0, 3));
                pal_data = CW'($urandom_range(0, 4095));
            end
            cycle();
            pal_we = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_hSync"}, 32'(hSync), 32'd1);
        chk({tag, "_vSync"}, 32'(vSync), 32'd1);
        chk({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
        chk({tag, "_en"}, 32'(pix_rd_en), 32'd0);
        chk({tag, "_addr"}, 32'(pix_rd_addr), 32'd0);
        chk({tag, "_frame_end"}, 32'(frame_end), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  wait_c;
        bit  seen;
        for (int i = 0; i < HA * VA; i++) mem[i] = PW'(i & 1);
        model_reset();
        green_cnt = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;
        model_reset();

        // Alternating columns through the default palette, two frames.
        run(2 * FR * DIV, 0);

        // Mid-frame palette write: index 1 becomes pure green.
        run(FR * DIV / 2, 0);
        pal_we = 1'b1; pal_idx = 2'd1; pal_data = 12'h0F0;
        cycle();
        pal_we = 1'b0;
        green_cnt = 0;
        run(FR * DIV / 2 - 1 + FR * DIV, 0);
        chk("green_pixels_seen", 32'(green_cnt > 0), 32'd1);

        // Random framebuffer contents and random palette writes.
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < HA * VA; i++) mem[i] = PW'($urandom_range(0, 3));
            run(FR * DIV, 1);
        end

        // Asynchronous reset in the middle of a line.
        run(FR * DIV / 3, 0);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        wait_c = 0; seen = 0;
        while (!seen && wait_c < 4 * FR * DIV) begin
            cycle();
            wait_c++;
            if (frame_end) seen = 1;
        end
        chk("first_frame_end_edge", seen ? 32'(c + 1) : 32'hFFFF_FFFF, 32'(FR * DIV));
        run(FR * DIV - 1, 0);
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < HA * VA; i++) mem[i] = PW'($urandom_range(0, 3));
            run(FR * DIV, 1);
        end

`ifdef CURSOR_OVERLAY_EN
        // Hold left long enough to hit the clamp, then cancel U+D, then random.
        BTNL = 1'b1;
        run(6 * FR * DIV, 0);
        BTNL = 1'b0; BTNU = 1'b1; BTND = 1'b1;
        run(2 * FR * DIV, 0);
        for (int f = 0; f < 8; f++) begin
            {BTNU, BTND, BTNL, BTNR} = 4'($urandom_range(0, 15));
            run(FR * DIV, 1);
        end
        {BTNU, BTND, BTNL, BTNR} = 4'd0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
